// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator.
// Scans the operands SLICE bits at a time from the most significant slice down
// and stops at the first slice that differs. In signed mode the sign bit of the
// top slice is inverted so an unsigned slice compare orders two's-complement values.
// Valid/ready handshakes on both the operand side and the result side.
module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int CW    = $clog2(WIDTH / SLICE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    slices_used
);

    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0]    IDX_TOP = IW'(NS - 1);
    localparam logic [SLICE-1:0] TOP_BIT = SLICE'(1) << (SLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              signed_r;
    logic [IW-1:0]     idx_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              gt_r;
    logic              eq_r;
    logic              lt_r;
    logic [CW-1:0]     slices_used_r;

    logic [SLICE-1:0]  sa_raw_s;
    logic [SLICE-1:0]  sb_raw_s;
    logic [SLICE-1:0]  sa_s;
    logic [SLICE-1:0]  sb_s;
    logic              flip_s;
    logic [CW-1:0]     used_s;

    // Select the slice under examination and apply the sign-bit inversion on the top slice.
    always_comb begin
        sa_raw_s = '0;
        sb_raw_s = '0;
        for (int i = 0; i < NS; i++) begin
            sa_raw_s = sa_raw_s | ((idx_r == IW'(i)) ? a_r[i*SLICE +: SLICE] : {SLICE{1'b0}});
            sb_raw_s = sb_raw_s | ((idx_r == IW'(i)) ? b_r[i*SLICE +: SLICE] : {SLICE{1'b0}});
        end
        flip_s = signed_r && (idx_r == IDX_TOP);
        sa_s   = sa_raw_s ^ (flip_s ? TOP_BIT : {SLICE{1'b0}});
        sb_s   = sb_raw_s ^ (flip_s ? TOP_BIT : {SLICE{1'b0}});
        used_s = CW'(NS) - CW'(idx_r);
    end

    // Control FSM: accept operands, scan slices MSB-first, hold the result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            a_r           <= '0;
            b_r           <= '0;
            signed_r      <= 1'b0;
            idx_r         <= IDX_TOP;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            gt_r          <= 1'b0;
            eq_r          <= 1'b0;
            lt_r          <= 1'b0;
            slices_used_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b;
                        signed_r   <= signed_mode;
                        idx_r      <= IDX_TOP;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_SCAN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (abort) begin
                        // Cancelled compare: no result, flags keep their previous values.
                        in_ready_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else if (sa_s != sb_s) begin
                        gt_r          <= (sa_s > sb_s);
                        lt_r          <= (sa_s < sb_s);
                        eq_r          <= 1'b0;
                        slices_used_r <= used_s;
                        out_valid_r   <= 1'b1;
                        state_r       <= ST_DONE;
                    end else if (idx_r == '0) begin
                        gt_r          <= 1'b0;
                        lt_r          <= 1'b0;
                        eq_r          <= 1'b1;
                        slices_used_r <= CW'(NS);
                        out_valid_r   <= 1'b1;
                        state_r       <= ST_DONE;
                    end else begin
                        idx_r <= idx_r - IW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign gt          = gt_r;
    assign eq          = eq_r;
    assign lt          = lt_r;
    assign slices_used = slices_used_r;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=32, SLICE=8).
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int NS    = WIDTH / SLICE;
    localparam int CW    = $clog2(NS + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [CW-1:0]    slices_used;

    int checks   = 0;
    int failures = 0;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .SLICE(SLICE), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt),
        .slices_used (slices_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        bit          sm;
        bit          eg;
        bit          ee;
        bit          el;
        int          ek;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: whole-word compare, slice count from the highest differing bit.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input bit msm,
                         output bit g, output bit e, output bit l, output int k);
        int hi;
        e = (ma == mb);
        if (msm) g = ($signed(ma) > $signed(mb));
        else     g = (ma > mb);
        l = !g && !e;
        hi = -1;
        for (int i = 0; i < WIDTH; i++) begin
            if (ma[i] != mb[i]) hi = i;
        end
        k = (hi < 0) ? NS : NS - (hi / SLICE);
    endtask

    // Launch one compare and wait for its result; flags and latency are checked.
    task automatic start_wait(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                              input bit tsm, input bit eg, input bit ee, input bit el,
                              input int ek);
        int cyc;
        check({nm, "_in_ready_pre"}, int'(in_ready), 1);
        a = ta; b = tb; signed_mode = tsm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; signed_mode = 1'($urandom_range(0, 1));
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < NS + 3);
        check({nm, "_latency"}, cyc, ek);
        check({nm, "_gt"}, int'(gt), int'(eg));
        check({nm, "_eq"}, int'(eq), int'(ee));
        check({nm, "_lt"}, int'(lt), int'(el));
        check({nm, "_slices"}, int'(slices_used), ek);
    endtask

    // Consume the pending result and check the return to idle.
    task automatic finish_txn(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({nm, "_ov_clr"}, int'(out_valid), 0);
        check({nm, "_in_ready_post"}, int'(in_ready), 1);
    endtask

    vec_t vecs[10];

    initial begin
        bit g, e, l;
        int k;
        logic [31:0] ra, rb;
        bit rsm;

        vecs[0] = '{32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[3] = '{32'h123400FF, 32'h12340100, 1'b0, 1'b0, 1'b0, 1'b1, 3};
        vecs[4] = '{32'h00000005, 32'h00000003, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        vecs[5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[7] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[8] = '{32'h00010000, 32'h00020000, 1'b1, 1'b0, 1'b0, 1'b1, 2};
        vecs[9] = '{32'h7F000000, 32'h7F000000, 1'b1, 1'b0, 1'b1, 1'b0, 4};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        abort = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_flags", int'({gt, eq, lt}), 0);
        check("rst_slices", int'(slices_used), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            start_wait($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].sm,
                       vecs[i].eg, vecs[i].ee, vecs[i].el, vecs[i].ek);
            finish_txn($sformatf("vec%0d", i));
        end

        // Stall in DONE for 5 cycles; abort during DONE must be ignored
        out_ready = 1'b0;
        start_wait("stall", 32'h123400FF, 32'h12340100, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        for (int i = 0; i < 5; i++) begin
            abort = (i == 2);
            @(posedge clk); #1;
            check("stall_ov", int'(out_valid), 1);
            check("stall_flags", int'({gt, eq, lt}), 1);
            check("stall_slices", int'(slices_used), 3);
            check("stall_in_ready", int'(in_ready), 0);
        end
        abort = 1'b0;
        finish_txn("stall");

        // Abort on the second SCAN cycle
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; signed_mode = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_scan_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_ov", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_flags_kept", int'({gt, eq, lt}), 1);
        @(posedge clk); #1;
        check("abort_ov_later", int'(out_valid), 0);
        start_wait("post_abort", 32'd5, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        finish_txn("post_abort");

        // Asynchronous reset mid-SCAN
        a = 32'h0; b = 32'h0; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_flags", int'({gt, eq, lt}), 0);
        check("midrst_slices", int'(slices_used), 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_ov", int'(out_valid), 0);
        start_wait("postrst", 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        finish_txn("postrst");

        // Randomized compares against the reference model
        for (int n = 0; n < 200; n++) begin
            ra  = $urandom;
            rsm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = ra;
                2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = {ra[31:16], 16'($urandom)};
            endcase
            model(ra, rb, rsm, g, e, l, k);
            start_wait("rand", ra, rb, rsm, g, e, l, k);
            finish_txn("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
